ha_array_reduce_seq: RTL and testbench

//  Back end of the unsigned 8x8 HA-array multiplier flow.
//  - Accepts one transaction: the four HA-array rows (b/t pairs) produced by the approximate front end.
//  - Reduces them sequentially, one row per clock, into a 16-bit unsigned product.
//  - Sits between the combinational partial-product front end and the consuming datapath.
//  - Uses valid/ready handshakes on both sides.

---
 rtl/ha_array_reduce_seq.sv | 133 +++++++++++++
 tb/tb_ha_array_reduce_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ha_array_reduce_seq.sv
// ha_array_reduce_seq
// Back end of the unsigned 8x8 HA-array multiplier. It captures the four
// b/t rows from the approximate front end, folds in one row per clock and
// presents a saturated 16-bit product behind a valid/ready handshake.
//
// Build option: define HA_ARRAY_BIAS_COMP_EN to add the constant BIAS to
// the final sum ahead of saturation. Left undefined, BIAS is not used.
//
// state | meaning
// IDLE  | waiting for a row set, in_ready high
// ACC   | adding row cnt into acc, one row per clock
// DONE  | product valid, held until the consumer takes it
module ha_array_reduce_seq #(
  parameter logic [15:0] BIAS = 16'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  ha_array_0_b,
  input  logic [8:0]  ha_array_0_t,
  input  logic [6:0]  ha_array_1_b,
  input  logic [8:0]  ha_array_1_t,
  input  logic [6:0]  ha_array_2_b,
  input  logic [8:0]  ha_array_2_t,
  input  logic [6:0]  ha_array_3_b,
  input  logic [8:0]  ha_array_3_t,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Each row stored as {b[6:0], t[8:0]}; index k is row k.
  logic [3:0][15:0] rows_q;
  logic [17:0]      acc;
  logic [1:0]       cnt;

  logic [15:0] row_sel;
  logic [9:0]  row_val;
  logic [17:0] row_term;
  logic [17:0] acc_sum;
  logic [17:0] final_sum;
  logic [15:0] final_sat;

`ifndef HA_ARRAY_BIAS_COMP_EN
  // BIAS only feeds the compensation adder; tie it off when that is absent.
  logic unused_bias;
  assign unused_bias = ^BIAS;
`endif

  // Row value for the current count, shifted into place and added to acc.
  always_comb begin
    row_sel   = rows_q[cnt];
    row_val   = {1'b0, row_sel[8:0]} + {1'b0, row_sel[15:9], 2'b00};
    row_term  = {8'b0, row_val} << {cnt, 1'b0};
    acc_sum   = acc + row_term;
`ifdef HA_ARRAY_BIAS_COMP_EN
    final_sum = acc_sum + {2'b00, BIAS};
`else
    final_sum = acc_sum;
`endif
    // Worst case (all rows max, plus BIAS) still fits 18 bits, so only
    // the top two bits need inspecting for saturation.
    final_sat = (|final_sum[17:16]) ? 16'hFFFF : final_sum[15:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ACC;
      end
      ACC: begin
        if (cnt == 2'd3) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Returning to IDLE (not straight to ACC) keeps accept and
        // product handoff in separate cycles.
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Row capture, accumulation and product load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rows_q <= {ha_array_3_b, ha_array_3_t,
                       ha_array_2_b, ha_array_2_t,
                       ha_array_1_b, ha_array_1_t,
                       ha_array_0_b, ha_array_0_t};
            acc    <= '0;
            cnt    <= '0;
          end
        end
        ACC: begin
          acc <= acc_sum;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) product <= final_sat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ha_array_reduce_seq.sv
// Directed bench for ha_array_reduce_seq: single-row and multi-row vectors,
// saturation, consumer back-pressure, and reset during ACC and DONE.
module tb_ha_array_reduce_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  b0, b1, b2, b3;
  logic [8:0]  t0, t1, t2, t3;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;

  int n_checks = 0;
  int n_pass   = 0;

  ha_array_reduce_seq #(.BIAS(16'd32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_b (b0),
    .ha_array_0_t (t0),
    .ha_array_1_b (b1),
    .ha_array_1_t (t1),
    .ha_array_2_b (b2),
    .ha_array_2_t (t2),
    .ha_array_3_b (b3),
    .ha_array_3_t (t3),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_rows(input logic [6:0] b0_v, input logic [8:0] t0_v,
                          input logic [6:0] b1_v, input logic [8:0] t1_v,
                          input logic [6:0] b2_v, input logic [8:0] t2_v,
                          input logic [6:0] b3_v, input logic [8:0] t3_v);
    b0 = b0_v; t0 = t0_v; b1 = b1_v; t1 = t1_v;
    b2 = b2_v; t2 = t2_v; b3 = b3_v; t3 = t3_v;
  endtask

  // Called #1 after a posedge with in_ready expected high.
  task automatic accept_now(input string tag);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; counts edges until out_valid.
  task automatic wait_out(input string tag, input logic [15:0] exp);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 32'd4);
    check({tag, "_product"}, {16'b0, product}, {16'b0, exp});
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ov_low"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [15:0] exp);
    accept_now(tag);
    wait_out(tag, exp);
    drain(tag);
  endtask

  logic [15:0] held;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_rows(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_product", {16'b0, product}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    set_rows(0, 0, 0, 0, 0, 0, 0, 0);
    run("zero", 16'h0000);

    set_rows(0, 9'h001, 0, 0, 0, 0, 0, 0);
    run("row0_t1", 16'h0001);

    set_rows(0, 0, 7'h01, 0, 0, 0, 0, 0);
    run("row1_b1", 16'h0010);

    // R0 = 3 + 4 = 7, R2 = 2 -> 2<<4 = 32, total 39.
    set_rows(7'h01, 9'h003, 0, 0, 0, 9'h002, 0, 0);
    run("mixed", 16'h0027);

    set_rows(0, 0, 0, 0, 0, 0, 7'h7F, 9'h1FF);
    run("row3_max", 16'hFEC0);

    set_rows(7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 7'h7F, 9'h1FF);
    run("all_max_sat", 16'hFFFF);

    // Back-pressure: product held, input ignored while DONE.
    set_rows(0, 9'h0AB, 0, 0, 0, 0, 0, 0);
    accept_now("stall");
    wait_out("stall", 16'h00AB);
    held = product;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      set_rows(7'h7F, 9'h1FF, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      check("stall_ov", {31'b0, out_valid}, 32'd1);
      check("stall_prod", {16'b0, product}, {16'b0, held});
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    end
    // in_valid held through the handshake edge must not be taken there.
    set_rows(0, 9'h002, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_ov_low", {31'b0, out_valid}, 32'd0);
    check("hs_idle", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("post_hs_accepted", {31'b0, in_ready}, 32'd0);
    wait_out("post_hs", 16'h0002);
    drain("post_hs");

    // Reset during ACC cycle 2.
    set_rows(0, 9'h1FF, 0, 9'h1FF, 0, 0, 0, 0);
    accept_now("rst_acc");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_acc_ov", {31'b0, out_valid}, 32'd0);
    check("rst_acc_prod", {16'b0, product}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_acc_ready", {31'b0, in_ready}, 32'd1);
    set_rows(0, 9'h005, 0, 0, 0, 0, 0, 0);
    run("after_rst", 16'h0005);

    // Reset while holding a result in DONE.
    set_rows(0, 9'h033, 0, 0, 0, 0, 0, 0);
    accept_now("rst_done");
    wait_out("rst_done", 16'h0033);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_done_ov", {31'b0, out_valid}, 32'd0);
    check("rst_done_prod", {16'b0, product}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    set_rows(0, 9'h001, 0, 0, 0, 0, 0, 0);
`ifdef HA_ARRAY_BIAS_COMP_EN
    run("bias", 16'h0021);
`else
    run("bias", 16'h0001);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
